// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer for the 5-stage RV64 core: stall/flush/forward selects,
// a registered action FSM, saturating stall/flush counters and a memory-wait watchdog.
module hazard_controller #(
  parameter int CNT_W        = 32,
  parameter int MAX_MEM_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             UseRs1D,
  input  logic             UseRs2D,
  input  logic             BrUseD,
  input  logic             PCSrcD,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteEnE,
  input  logic             MemReadEnE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteEnM,
  input  logic             MemReadEnM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteEnW,
  input  logic             MemBusyM,
  input  logic             PerfClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAD,
  output logic [1:0]       ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic             Timeout
);

  typedef enum logic [1:0] {RUN = 2'd0, HAZ = 2'd1, MEMW = 2'd2, REDIR = 2'd3} stateT;

  localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  stateT             stateQ, stateNext;
  logic [WAIT_W-1:0] waitCnt, waitNext;
  logic              useAE, useBE, useAM, useBM;
  logic              loadUse, branchHaz, hazard;

  // x0 is hardwired, so it can never carry a dependency
  function automatic logic match(input logic [4:0] x, input logic [4:0] r);
    return (x != 5'd0) && (x == r);
  endfunction

  assign useAE = UseRs1D && match(Rs1D, RdE);
  assign useBE = UseRs2D && match(Rs2D, RdE);
  assign useAM = UseRs1D && match(Rs1D, RdM);
  assign useBM = UseRs2D && match(Rs2D, RdM);

  assign loadUse   = MemReadEnE && (useAE || useBE);
  assign branchHaz = BrUseD && ((RegWriteEnE && (useAE || useBE)) ||
                                (MemReadEnM && (useAM || useBM)));
  assign hazard    = loadUse || branchHaz;

  // A hazard outranks a redirect because the branch operands are not yet valid
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    stateNext = RUN;
    if (MemBusyM) begin
      StallF    = 1'b1;
      StallD    = 1'b1;
      StallE    = 1'b1;
      StallM    = 1'b1;
      StallW    = 1'b1;
      stateNext = MEMW;
    end else if (hazard) begin
      StallF    = 1'b1;
      StallD    = 1'b1;
      FlushE    = 1'b1;
      stateNext = HAZ;
    end else if (PCSrcD) begin
      FlushD    = 1'b1;
      stateNext = REDIR;
    end
  end

  // Loads in MEM are excluded on the ID side since their data is not available yet
  always_comb begin
    ForwardAD = 2'b00;
    ForwardBD = 2'b00;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteEnM && !MemReadEnM && match(Rs1D, RdM)) ForwardAD = 2'b10;
    else if (RegWriteEnW && match(Rs1D, RdW))           ForwardAD = 2'b01;
    if (RegWriteEnM && !MemReadEnM && match(Rs2D, RdM)) ForwardBD = 2'b10;
    else if (RegWriteEnW && match(Rs2D, RdW))           ForwardBD = 2'b01;
    if (RegWriteEnM && match(Rs1E, RdM))                ForwardAE = 2'b10;
    else if (RegWriteEnW && match(Rs1E, RdW))           ForwardAE = 2'b01;
    if (RegWriteEnM && match(Rs2E, RdM))                ForwardBE = 2'b10;
    else if (RegWriteEnW && match(Rs2E, RdW))           ForwardBE = 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= RUN;
    else     stateQ <= stateNext;
  end

  assign State = stateQ;

  assign waitNext = !MemBusyM ? '0 :
                    (waitCnt == WAIT_MAX) ? waitCnt : waitCnt + WAIT_W'(1);

  // PerfClr takes precedence over any counting event in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt  <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
      Timeout  <= 1'b0;
    end else begin
      waitCnt <= waitNext;
      if (PerfClr) begin
        StallCnt <= '0;
        FlushCnt <= '0;
        Timeout  <= 1'b0;
      end else begin
        if (StallD && StallCnt != CNT_MAX) StallCnt <= StallCnt + CNT_W'(1);
        if (FlushD && FlushCnt != CNT_MAX) FlushCnt <= FlushCnt + CNT_W'(1);
        if (waitNext == WAIT_MAX) Timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller, using narrow counters
// so that counter saturation is reachable in a short run.
module tb_hazard_controller;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic UseRs1D, UseRs2D, BrUseD, PCSrcD;
  logic RegWriteEnE, MemReadEnE, RegWriteEnM, MemReadEnM, RegWriteEnW;
  logic MemBusyM, PerfClr;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, Timeout;
  logic [1:0] ForwardAD, ForwardBD, ForwardAE, ForwardBE, State;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int checks = 0;
  int errors = 0;
  int hazRun = 0;

  hazard_controller #(.CNT_W(CNT_W), .MAX_MEM_WAIT(16)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
    .BrUseD(BrUseD), .PCSrcD(PCSrcD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteEnE(RegWriteEnE), .MemReadEnE(MemReadEnE),
    .RdM(RdM), .RegWriteEnM(RegWriteEnM), .MemReadEnM(MemReadEnM),
    .RdW(RdW), .RegWriteEnW(RegWriteEnW),
    .MemBusyM(MemBusyM), .PerfClr(PerfClr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .State(State), .StallCnt(StallCnt), .FlushCnt(FlushCnt), .Timeout(Timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      $error("[TB] check %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs;
    Rs1D = 0; Rs2D = 0; UseRs1D = 0; UseRs2D = 0; BrUseD = 0; PCSrcD = 0;
    Rs1E = 0; Rs2E = 0; RdE = 0; RegWriteEnE = 0; MemReadEnE = 0;
    RdM = 0; RegWriteEnM = 0; MemReadEnM = 0; RdW = 0; RegWriteEnW = 0;
    MemBusyM = 0; PerfClr = 0;
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // HAZ may last at most two consecutive cycles while memory is ready
  always @(negedge clk) begin
    if (!rst && State == 2'd1) begin
      hazRun++;
      checks++;
      assert (hazRun <= 2) else begin
        errors++;
        $display("[TB] FAIL hazRun: observed %0d expected <= 2", hazRun);
        $error("[TB] HAZ persisted %0d cycles", hazRun);
      end
    end else begin
      hazRun = 0;
    end
  end

  initial begin
    idleInputs();
    rst = 1'b1;
    #12;
    checkOutput("rstState", State, 0);
    checkOutput("rstStallCnt", StallCnt, 0);
    checkOutput("rstFlushCnt", FlushCnt, 0);
    checkOutput("rstTimeout", Timeout, 0);
    rst = 1'b0;

    // Load-use on x5
    MemReadEnE = 1; RegWriteEnE = 1; RdE = 5; Rs1D = 5; UseRs1D = 1;
    #1;
    checkOutput("luStallF", StallF, 1);
    checkOutput("luStallD", StallD, 1);
    checkOutput("luFlushE", FlushE, 1);
    checkOutput("luFlushD", FlushD, 0);
    checkOutput("luStallE", StallE, 0);
    applyStimulus(1);
    checkOutput("luState", State, 1);
    checkOutput("luStallCnt", StallCnt, 1);
    idleInputs();
    applyStimulus(1);
    checkOutput("luRunState", State, 0);

    // x0 and unused operands never create hazards
    MemReadEnE = 1; RegWriteEnE = 1; RdE = 0; Rs1D = 0; UseRs1D = 1;
    #1 checkOutput("x0NoStall", StallD, 0);
    RdE = 5; Rs1D = 5; UseRs1D = 0;
    #1 checkOutput("unusedNoStall", StallD, 0);
    idleInputs();

    // Branch on x6 behind an ALU producer: one stall, then MEM forward
    BrUseD = 1; UseRs1D = 1; Rs1D = 6; RegWriteEnE = 1; RdE = 6;
    #1 checkOutput("brAluStall", StallD, 1);
    applyStimulus(1);
    checkOutput("brAluStallCnt", StallCnt, 2);
    RegWriteEnE = 0; RdE = 0; RegWriteEnM = 1; RdM = 6;
    #1;
    checkOutput("brAluNoStall", StallD, 0);
    checkOutput("brAluFwdAD", ForwardAD, 2'b10);
    applyStimulus(1);
    checkOutput("brAluRun", State, 0);
    idleInputs();

    // Branch on x7 behind a load: stall in EX, stall in MEM, then WB forward
    BrUseD = 1; UseRs1D = 1; Rs1D = 7; MemReadEnE = 1; RegWriteEnE = 1; RdE = 7;
    #1 checkOutput("brLdStallEx", StallD, 1);
    applyStimulus(1);
    MemReadEnE = 0; RegWriteEnE = 0; RdE = 0; MemReadEnM = 1; RegWriteEnM = 1; RdM = 7;
    #1;
    checkOutput("brLdStallMem", StallD, 1);
    checkOutput("brLdNoMemFwd", ForwardAD, 2'b00);
    applyStimulus(1);
    checkOutput("brLdState", State, 1);
    checkOutput("brLdStallCnt", StallCnt, 4);
    MemReadEnM = 0; RegWriteEnM = 0; RdM = 0; RegWriteEnW = 1; RdW = 7;
    #1;
    checkOutput("brLdNoStall", StallD, 0);
    checkOutput("brLdFwdAD", ForwardAD, 2'b01);
    applyStimulus(1);
    checkOutput("brLdRun", State, 0);
    idleInputs();

    // Redirect alone, then redirect suppressed by a hazard
    PCSrcD = 1;
    #1;
    checkOutput("redirFlushD", FlushD, 1);
    checkOutput("redirStallD", StallD, 0);
    applyStimulus(1);
    checkOutput("redirState", State, 3);
    checkOutput("redirFlushCnt", FlushCnt, 1);
    MemReadEnE = 1; RegWriteEnE = 1; RdE = 5; Rs1D = 5; UseRs1D = 1;
    #1;
    checkOutput("redirHazFlushD", FlushD, 0);
    checkOutput("redirHazFlushE", FlushE, 1);
    applyStimulus(1);
    checkOutput("redirHazState", State, 1);
    checkOutput("redirHazFlushCnt", FlushCnt, 1);
    checkOutput("redirHazStallCnt", StallCnt, 5);
    idleInputs();
    applyStimulus(1);

    // Forwarding priority and exclusions
    Rs1E = 3; Rs2E = 3; RegWriteEnM = 1; RdM = 3; RegWriteEnW = 1; RdW = 3;
    #1;
    checkOutput("fwdAEmem", ForwardAE, 2'b10);
    checkOutput("fwdBEmem", ForwardBE, 2'b10);
    RegWriteEnM = 0;
    #1 checkOutput("fwdAEwb", ForwardAE, 2'b01);
    idleInputs();
    Rs1D = 0; RdM = 0; RegWriteEnM = 1;
    #1 checkOutput("fwdADx0", ForwardAD, 2'b00);
    Rs2D = 9; RdM = 9; MemReadEnM = 1; RdW = 9; RegWriteEnW = 1;
    #1 checkOutput("fwdBDloadM", ForwardBD, 2'b01);
    idleInputs();

    // Memory busy dominates hazard and redirect; watchdog at 16 cycles
    MemBusyM = 1; PCSrcD = 1;
    MemReadEnE = 1; RegWriteEnE = 1; RdE = 5; Rs1D = 5; UseRs1D = 1;
    #1;
    checkOutput("busyStalls", {StallF, StallD, StallE, StallM, StallW}, 5'b11111);
    checkOutput("busyFlushes", {FlushD, FlushE}, 2'b00);
    applyStimulus(15);
    checkOutput("busyTimeout15", Timeout, 0);
    applyStimulus(1);
    checkOutput("busyTimeout16", Timeout, 1);
    checkOutput("busyState", State, 2);
    checkOutput("stallSat", StallCnt, 15);
    checkOutput("busyFlushCnt", FlushCnt, 1);
    idleInputs();
    applyStimulus(1);
    checkOutput("timeoutSticky", Timeout, 1);
    checkOutput("idleState", State, 0);

    // PerfClr wins over a coincident flush event
    PerfClr = 1; PCSrcD = 1;
    applyStimulus(1);
    checkOutput("clrFlushCnt", FlushCnt, 0);
    checkOutput("clrStallCnt", StallCnt, 0);
    checkOutput("clrTimeout", Timeout, 0);
    checkOutput("clrState", State, 3);
    PerfClr = 0;
    applyStimulus(16);
    checkOutput("flushSat", FlushCnt, 15);
    idleInputs();

    // Non-consecutive busy cycles must not trip the watchdog
    MemBusyM = 1;
    applyStimulus(10);
    MemBusyM = 0;
    applyStimulus(1);
    MemBusyM = 1;
    applyStimulus(10);
    checkOutput("wdogBroken", Timeout, 0);
    checkOutput("busyStallCnt", StallCnt, 15);
    idleInputs();

    // Asynchronous reset in the middle of a stall
    MemReadEnE = 1; RegWriteEnE = 1; RdE = 5; Rs1D = 5; UseRs1D = 1;
    applyStimulus(1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncStallCnt", StallCnt, 0);
    checkOutput("asyncFlushCnt", FlushCnt, 0);
    checkOutput("asyncState", State, 0);
    checkOutput("asyncCombStallD", StallD, 1);
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("postRstStallCnt", StallCnt, 1);
    checkOutput("postRstState", State, 1);
    idleInputs();
    applyStimulus(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
